eth_rx_filter: RTL and testbench
================================

# eth_rx_filter

Parametrised, byte-wide Ethernet receive MAC front end. It sits between the PHY byte interface and the payload consumer. It detects preamble and SFD, filters on destination MAC and optional EtherType, strips the header and FCS, and checks the standard Ethernet CRC-32. Payload leaves through a buffered valid/ready stream, and the frame verdict is tagged on the last beat so the consumer tolerates backpressure without losing frame boundaries.

## Interface
- MAC_ADDR, 48'h001122334455: station address accepted by the destination filter.
- PREAMBLE_MIN, 7: minimum count of consecutive 0x55 bytes required before 0xD5.
- FIFO_DEPTH, 16: output buffer entries; must be a power of 2 and ≥ 4.
- MAX_PAYLOAD, 1500: payload bytes beyond this value are an oversize error.
- ETYPE_FILTER_EN, 0: when 1, frames with an EtherType other than ETYPE are dropped.
- ETYPE, 16'h88B5: EtherType accepted when filtering is enabled.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- rx_byte  in  8  PHY byte.
- rx_valid  in  1  high for every byte of a frame; low between frames (frame end = first low cycle).
- promisc  in  1  when 1, the destination MAC filter is bypassed.
- m_data  out  8  payload byte.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the beat.
- m_last  out  1  final payload beat of the frame.
- m_err  out  1  frame bad; meaningful only when m_last is high.
- stat_ok, stat_crc_err, stat_overflow, stat_oversize, stat_runt, stat_filtered  out  1 each  one-cycle pulses at frame end.

## Operation
- FSM states:
  - IDLE → PREAMBLE on rx_valid with 0x55.
  - PREAMBLE counts 0x55 bytes, saturating at PREAMBLE_MIN.
    - 0xD5 with count ≥ PREAMBLE_MIN → HEADER.
    - Any other byte → DISCARD.
    - rx_valid low → IDLE.
  - HEADER takes 14 bytes: destination (6), source (6), EtherType (2), then → PAYLOAD.
  - PAYLOAD runs until rx_valid goes low, then → IDLE.
  - DISCARD waits for rx_valid low, then → IDLE.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Covers every byte after the SFD, including the FCS.
  - CRC is good iff the register equals 0xDEBB20E3 at frame end.
- Destination filter:
  - Pass when destination == MAC_ADDR, destination == broadcast, or promisc = 1.
  - Failing frames finish in PAYLOAD with no pushes and pulse stat_filtered; no CRC verdict is reported.
- EtherType filter: same drop behaviour as the destination filter, when ETYPE_FILTER_EN = 1.
- Payload hold-back:
  - Payload bytes pass through a 5-byte hold line: 4 bytes to strip the FCS, 1 byte to allow tagging of the last beat.
  - A byte is pushed into the FIFO when displaced from the oldest slot.
- Frame end with ≥ 5 held payload bytes:
  - Push the oldest held byte with m_last = 1.
  - m_err = CRC bad, or overflow, or oversize.
- Runt: a frame ending before 14 header bytes plus 5 payload bytes have arrived pushes nothing and pulses stat_runt only.
- Overflow:
  - A data push requires ≥ 2 free entries, so one entry is always reserved for the last beat.
  - On failure, set overflow; further data pushes are suppressed; the last beat is still pushed with m_err = 1.
- Oversize: once MAX_PAYLOAD bytes have been pushed, further data pushes are suppressed and the frame is flagged bad.
- Status pulses at frame end:
  - stat_ok only if the frame was accepted with no error.
  - Otherwise every applicable error pulse asserts (may be simultaneous).
- Payload and header counters saturate and never wrap.

## Timing
- Reset values:
  - m_valid, m_last, m_err and all stat_* are 0; m_data is 0.
  - FIFO is empty.
  - FSM is in DISCARD, so a frame in flight at reset is ignored until rx_valid goes low.
- Payload byte k is pushed on the edge that samples payload byte k+5.
- The last beat is pushed on the edge that samples rx_valid low.
- stat_* pulses assert in the cycle after that edge.
- FIFO write → m_valid high: 1 cycle.
- Beat transfer occurs when m_valid && m_ready.
- m_data, m_last and m_err hold stable while m_valid && !m_ready.
- Simultaneous push and pop when the FIFO is full-minus-one is legal; free-space checks use the pre-edge count.
- A new preamble is accepted in the cycle after frame end; the FSM needs no idle gap beyond the single rx_valid-low cycle.

## Structure
- Package eth_pkg contains:
  - the FSM state enum;
  - CRC_POLY_REFL, CRC_INIT and CRC_RESIDUE;
  - MAC_BROADCAST and HDR_LEN = 14;
  - a byte-step crc32 function.
- Sub-module eth_rx_fifo: synchronous FIFO, 10 bits wide ({err, last, data}), parametrised depth, exposing a free-entry count.

## Test plan
- Accepted frame: 7×0x55, 0xD5, destination 00:11:22:33:44:55, EtherType 0x0800, payload 0x00..0x2D, correct FCS → 46 beats, last on 0x2D, m_err = 0, stat_ok.
- Bit-flipped payload: same frame with payload byte 10 XOR 0x01 → 46 beats, m_err = 1 on the last beat, stat_crc_err.
- Filtered destination: destination 00:11:22:33:44:66 with promisc = 0 → no beats, stat_filtered; same frame with promisc = 1 → 46 beats, stat_ok.
- Overflow: FIFO_DEPTH = 16, m_ready held 0 for the whole frame → 15 data beats plus a last beat with m_err = 1, stat_overflow; then release m_ready and drain 16 beats.
- Short preamble and runt: 3×0x55 + 0xD5 → nothing emitted; valid preamble followed by only 16 post-SFD bytes → stat_runt, no beats.
- Mid-frame reset: assert rst at payload byte 20 → no beats and no stat pulses; the next back-to-back frame, separated by one rx_valid-low cycle, is received correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types, constants and the CRC-32 byte step for the Ethernet receive front end.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DISCARD
    } eth_state_e;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;
    localparam int unsigned HDR_LEN       = 14;
    // 4 bytes hide the FCS, 1 more lets the final payload byte be tagged as last.
    localparam int unsigned HOLD_LEN      = 5;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_fifo.sv
// Synchronous FIFO for {err, last, data} beats; outputs read as zero while empty.
module eth_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     free_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign do_wr = wr_en_i && (count_q != CW'(DEPTH));
    assign do_rd = rd_en_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign valid_o   = (count_q != '0);
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign free_o    = CW'(DEPTH) - count_q;

endmodule

// File: rtl/eth_rx_filter.sv
// Ethernet receive front end: preamble/SFD detection, address/EtherType filtering,
// header and FCS stripping, CRC-32 check, buffered payload stream with per-frame verdict.
module eth_rx_filter
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR        = 48'h0011_2233_4455,
    parameter int unsigned PREAMBLE_MIN    = 7,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned MAX_PAYLOAD     = 1500,
    parameter logic        ETYPE_FILTER_EN = 1'b0,
    parameter logic [15:0] ETYPE           = 16'h88B5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       promisc,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       m_err,
    output logic       stat_ok,
    output logic       stat_crc_err,
    output logic       stat_overflow,
    output logic       stat_oversize,
    output logic       stat_runt,
    output logic       stat_filtered
);

    localparam int unsigned PW = $clog2(PREAMBLE_MIN + 1);
    localparam int unsigned HW = $clog2(HDR_LEN + 1);
    localparam int unsigned KW = $clog2(HOLD_LEN + 1);
    localparam int unsigned LW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    eth_state_e              state_q, state_d;
    logic [PW-1:0]           pre_cnt_q, pre_cnt_d;
    logic [HW-1:0]           hdr_cnt_q, hdr_cnt_d;
    logic [31:0]             crc_q, crc_d;
    logic [47:0]             dst_q, dst_d;
    logic [7:0]              etype_hi_q, etype_hi_d;
    logic                    accept_q, accept_d;
    logic [HOLD_LEN*8-1:0]   hold_q, hold_d;
    logic [KW-1:0]           hold_cnt_q, hold_cnt_d;
    logic [LW-1:0]           pay_cnt_q, pay_cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    ovs_q, ovs_d;

    logic stat_ok_q, stat_ok_d;
    logic stat_crc_err_q, stat_crc_err_d;
    logic stat_overflow_q, stat_overflow_d;
    logic stat_oversize_q, stat_oversize_d;
    logic stat_runt_q, stat_runt_d;
    logic stat_filtered_q, stat_filtered_d;

    logic          push_en;
    logic [9:0]    push_data;
    logic [9:0]    fifo_rd;
    logic [CW-1:0] fifo_free;

    logic [31:0] crc_next;
    logic [7:0]  hold_oldest;
    logic        dst_ok, etype_ok, crc_bad, ovs_end, last_err;

    assign crc_next    = crc32_step(crc_q, rx_byte);
    assign hold_oldest = hold_q[HOLD_LEN*8-1 -: 8];
    assign dst_ok      = (dst_q == MAC_ADDR) || (dst_q == MAC_BROADCAST) || promisc;
    assign etype_ok    = !ETYPE_FILTER_EN || ({etype_hi_q, rx_byte} == ETYPE);
    assign crc_bad     = (crc_q != CRC_RESIDUE);
    // A full push count at frame end means the pending last beat is one byte too many.
    assign ovs_end     = ovs_q || (pay_cnt_q == LW'(MAX_PAYLOAD));
    assign last_err    = crc_bad || ovf_q || ovs_end;

    always_comb begin
        state_d         = state_q;
        pre_cnt_d       = pre_cnt_q;
        hdr_cnt_d       = hdr_cnt_q;
        crc_d           = crc_q;
        dst_d           = dst_q;
        etype_hi_d      = etype_hi_q;
        accept_d        = accept_q;
        hold_d          = hold_q;
        hold_cnt_d      = hold_cnt_q;
        pay_cnt_d       = pay_cnt_q;
        ovf_d           = ovf_q;
        ovs_d           = ovs_q;
        stat_ok_d       = 1'b0;
        stat_crc_err_d  = 1'b0;
        stat_overflow_d = 1'b0;
        stat_oversize_d = 1'b0;
        stat_runt_d     = 1'b0;
        stat_filtered_d = 1'b0;
        push_en         = 1'b0;
        push_data       = '0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_byte == PREAMBLE_BYTE) begin
                    state_d   = ST_PREAMBLE;
                    pre_cnt_d = PW'(1);
                end
            end

            ST_PREAMBLE: begin
                if (!rx_valid) begin
                    state_d = ST_IDLE;
                end else if (rx_byte == PREAMBLE_BYTE) begin
                    if (pre_cnt_q != PW'(PREAMBLE_MIN)) begin
                        pre_cnt_d = pre_cnt_q + PW'(1);
                    end
                end else if (rx_byte == SFD_BYTE && pre_cnt_q >= PW'(PREAMBLE_MIN)) begin
                    state_d    = ST_HEADER;
                    hdr_cnt_d  = '0;
                    crc_d      = CRC_INIT;
                    hold_cnt_d = '0;
                    pay_cnt_d  = '0;
                    ovf_d      = 1'b0;
                    ovs_d      = 1'b0;
                    accept_d   = 1'b0;
                end else begin
                    state_d = ST_DISCARD;
                end
            end

            ST_HEADER: begin
                if (!rx_valid) begin
                    state_d     = ST_IDLE;
                    stat_runt_d = 1'b1;
                end else begin
                    crc_d = crc_next;
                    if (hdr_cnt_q < HW'(6)) begin
                        dst_d = {dst_q[39:0], rx_byte};
                    end
                    if (hdr_cnt_q == HW'(HDR_LEN - 2)) begin
                        etype_hi_d = rx_byte;
                    end
                    if (hdr_cnt_q == HW'(HDR_LEN - 1)) begin
                        state_d  = ST_PAYLOAD;
                        accept_d = dst_ok && etype_ok;
                    end
                    if (hdr_cnt_q != HW'(HDR_LEN)) begin
                        hdr_cnt_d = hdr_cnt_q + HW'(1);
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!rx_valid) begin
                    state_d = ST_IDLE;
                    if (hold_cnt_q != KW'(HOLD_LEN)) begin
                        stat_runt_d = 1'b1;
                    end else if (!accept_q) begin
                        stat_filtered_d = 1'b1;
                    end else begin
                        push_en         = 1'b1;
                        push_data       = {last_err, 1'b1, hold_oldest};
                        stat_ok_d       = !last_err;
                        stat_crc_err_d  = crc_bad;
                        stat_overflow_d = ovf_q;
                        stat_oversize_d = ovs_end;
                    end
                end else begin
                    crc_d  = crc_next;
                    hold_d = {hold_q[HOLD_LEN*8-9:0], rx_byte};
                    if (hold_cnt_q != KW'(HOLD_LEN)) begin
                        hold_cnt_d = hold_cnt_q + KW'(1);
                    end else if (accept_q) begin
                        if (pay_cnt_q == LW'(MAX_PAYLOAD)) begin
                            ovs_d = 1'b1;
                        end else begin
                            pay_cnt_d = pay_cnt_q + LW'(1);
                            // Keep one entry free so the last beat always fits.
                            if (!ovf_q) begin
                                if (fifo_free >= CW'(2)) begin
                                    push_en   = 1'b1;
                                    push_data = {2'b00, hold_oldest};
                                end else begin
                                    ovf_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end

            ST_DISCARD: begin
                if (!rx_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_DISCARD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_DISCARD;
            pre_cnt_q       <= '0;
            hdr_cnt_q       <= '0;
            crc_q           <= CRC_INIT;
            dst_q           <= '0;
            etype_hi_q      <= '0;
            accept_q        <= 1'b0;
            hold_q          <= '0;
            hold_cnt_q      <= '0;
            pay_cnt_q       <= '0;
            ovf_q           <= 1'b0;
            ovs_q           <= 1'b0;
            stat_ok_q       <= 1'b0;
            stat_crc_err_q  <= 1'b0;
            stat_overflow_q <= 1'b0;
            stat_oversize_q <= 1'b0;
            stat_runt_q     <= 1'b0;
            stat_filtered_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pre_cnt_q       <= pre_cnt_d;
            hdr_cnt_q       <= hdr_cnt_d;
            crc_q           <= crc_d;
            dst_q           <= dst_d;
            etype_hi_q      <= etype_hi_d;
            accept_q        <= accept_d;
            hold_q          <= hold_d;
            hold_cnt_q      <= hold_cnt_d;
            pay_cnt_q       <= pay_cnt_d;
            ovf_q           <= ovf_d;
            ovs_q           <= ovs_d;
            stat_ok_q       <= stat_ok_d;
            stat_crc_err_q  <= stat_crc_err_d;
            stat_overflow_q <= stat_overflow_d;
            stat_oversize_q <= stat_oversize_d;
            stat_runt_q     <= stat_runt_d;
            stat_filtered_q <= stat_filtered_d;
        end
    end

    eth_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push_en),
        .wr_data_i (push_data),
        .rd_en_i   (m_ready),
        .rd_data_o (fifo_rd),
        .valid_o   (m_valid),
        .free_o    (fifo_free)
    );

    assign {m_err, m_last, m_data} = fifo_rd;

    assign stat_ok       = stat_ok_q;
    assign stat_crc_err  = stat_crc_err_q;
    assign stat_overflow = stat_overflow_q;
    assign stat_oversize = stat_oversize_q;
    assign stat_runt     = stat_runt_q;
    assign stat_filtered = stat_filtered_q;

endmodule

// File: tb/tb_eth_rx_filter.sv
// Directed bench for eth_rx_filter: frames are built with an independent bit-serial CRC model.
module tb_eth_rx_filter;

    localparam logic [47:0] STATION = 48'h0011_2233_4455;
    localparam logic [47:0] OTHER   = 48'h0011_2233_4466;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       promisc;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       m_err;
    logic       stat_ok, stat_crc_err, stat_overflow, stat_oversize, stat_runt, stat_filtered;

    int checks;
    int failures;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_data[$];
    logic       got_last[$];
    logic       got_err[$];
    int n_ok, n_crc, n_ovf, n_ovs, n_runt, n_filt;

    eth_rx_filter #(
        .MAC_ADDR        (STATION),
        .PREAMBLE_MIN    (7),
        .FIFO_DEPTH      (16),
        .MAX_PAYLOAD     (1500),
        .ETYPE_FILTER_EN (1'b0),
        .ETYPE           (16'h88B5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .promisc       (promisc),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .m_err         (m_err),
        .stat_ok       (stat_ok),
        .stat_crc_err  (stat_crc_err),
        .stat_overflow (stat_overflow),
        .stat_oversize (stat_oversize),
        .stat_runt     (stat_runt),
        .stat_filtered (stat_filtered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_err.push_back(m_err);
            end
            if (stat_ok)       n_ok++;
            if (stat_crc_err)  n_crc++;
            if (stat_overflow) n_ovf++;
            if (stat_oversize) n_ovs++;
            if (stat_runt)     n_runt++;
            if (stat_filtered) n_filt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    function automatic logic [23:0] stats();
        return {4'(n_ok), 4'(n_crc), 4'(n_ovf), 4'(n_ovs), 4'(n_runt), 4'(n_filt)};
    endfunction

    function automatic int data_errs();
        int e;
        e = (got_data.size() > exp_q.size()) ? got_data.size() - exp_q.size()
                                             : exp_q.size() - got_data.size();
        for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
            if (got_data[i] !== exp_q[i]) e++;
        return e;
    endfunction

    function automatic int last_errs();
        int e;
        e = 0;
        foreach (got_last[i])
            if (got_last[i] !== (i == got_last.size() - 1)) e++;
        return e;
    endfunction

    function automatic logic final_err();
        if (got_err.size() == 0) return 1'bx;
        return got_err[got_err.size() - 1];
    endfunction

    task automatic clear_obs();
        got_data.delete();
        got_last.delete();
        got_err.delete();
        n_ok = 0; n_crc = 0; n_ovf = 0; n_ovs = 0; n_runt = 0; n_filt = 0;
    endtask

    // Preamble, SFD, dst, src, EtherType 0x0800, payload k&0xFF, FCS; flip_idx corrupts one payload byte after FCS.
    task automatic build_frame(input int pre_n, input logic [47:0] dst, input int plen, input int flip_idx);
        logic [7:0]  body[$];
        logic [31:0] c;
        tx_q.delete();
        exp_q.delete();
        repeat (pre_n) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) body.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(8'hA0 + 8'(i));
        body.push_back(8'h08);
        body.push_back(8'h00);
        for (int k = 0; k < plen; k++) body.push_back(8'(k));
        c = 32'hFFFF_FFFF;
        foreach (body[i]) c = crc_upd(c, body[i]);
        c = ~c;
        body.push_back(c[7:0]);
        body.push_back(c[15:8]);
        body.push_back(c[23:16]);
        body.push_back(c[31:24]);
        if (flip_idx >= 0) body[14 + flip_idx] = body[14 + flip_idx] ^ 8'h01;
        for (int k = 0; k < plen; k++) exp_q.push_back(body[14 + k]);
        foreach (body[i]) tx_q.push_back(body[i]);
    endtask

    // Sends tx_q then one rx_valid-low cycle; rst_at >= 0 pulses reset with that byte.
    task automatic send_frame(input int rst_at);
        foreach (tx_q[i]) begin
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
                clear_obs();
            end
            if (i == rst_at) rst = 1'b1;
            rx_valid = 1'b1;
            rx_byte  = tx_q[i];
        end
        @(posedge clk); #1;
        if (rst) begin
            rst = 1'b0;
            clear_obs();
        end
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; promisc = 1'b0; m_ready = 1'b1;
        idle(3);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        checks++; if ({m_data, m_last, m_err} !== 10'h000) begin failures++; $display("FAIL reset_beat got=%03h exp=000", {m_data, m_last, m_err}); end
        checks++; if ({stat_ok, stat_crc_err, stat_overflow, stat_oversize, stat_runt, stat_filtered} !== 6'b0) begin
            failures++; $display("FAIL reset_stats got=%06b exp=000000", {stat_ok, stat_crc_err, stat_overflow, stat_oversize, stat_runt, stat_filtered}); end
        // Frame already in flight as reset releases: must be ignored until rx_valid drops.
        build_frame(10, STATION, 46, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 0) begin failures++; $display("FAIL reset_inflight_beats got=%0d exp=0", got_data.size()); end
        checks++; if (stats() !== 24'h000000) begin failures++; $display("FAIL reset_inflight_stats got=%06h exp=000000", stats()); end
    endtask

    task automatic test_accept();
        build_frame(7, STATION, 46, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 46) begin failures++; $display("FAIL accept_beats got=%0d exp=46", got_data.size()); end
        checks++; if (data_errs() !== 0) begin failures++; $display("FAIL accept_data got=%0d exp=0 errors", data_errs()); end
        checks++; if (last_errs() !== 0) begin failures++; $display("FAIL accept_last got=%0d exp=0 errors", last_errs()); end
        checks++; if (final_err() !== 1'b0) begin failures++; $display("FAIL accept_err got=%0b exp=0", final_err()); end
        checks++; if (stats() !== 24'h100000) begin failures++; $display("FAIL accept_stats got=%06h exp=100000", stats()); end
    endtask

    task automatic test_crc_error();
        build_frame(7, STATION, 46, 10);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 46) begin failures++; $display("FAIL crc_beats got=%0d exp=46", got_data.size()); end
        checks++; if (data_errs() !== 0) begin failures++; $display("FAIL crc_data got=%0d exp=0 errors", data_errs()); end
        checks++; if (final_err() !== 1'b1) begin failures++; $display("FAIL crc_err got=%0b exp=1", final_err()); end
        checks++; if (stats() !== 24'h010000) begin failures++; $display("FAIL crc_stats got=%06h exp=010000", stats()); end
    endtask

    task automatic test_filter();
        build_frame(7, OTHER, 46, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 0) begin failures++; $display("FAIL filt_beats got=%0d exp=0", got_data.size()); end
        checks++; if (stats() !== 24'h000001) begin failures++; $display("FAIL filt_stats got=%06h exp=000001", stats()); end
        promisc = 1'b1;
        clear_obs();
        send_frame(-1);
        idle(20);
        promisc = 1'b0;
        checks++; if (got_data.size() !== 46) begin failures++; $display("FAIL promisc_beats got=%0d exp=46", got_data.size()); end
        checks++; if (data_errs() !== 0) begin failures++; $display("FAIL promisc_data got=%0d exp=0 errors", data_errs()); end
        checks++; if (stats() !== 24'h100000) begin failures++; $display("FAIL promisc_stats got=%06h exp=100000", stats()); end
        build_frame(7, BCAST, 46, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 46) begin failures++; $display("FAIL bcast_beats got=%0d exp=46", got_data.size()); end
        checks++; if (stats() !== 24'h100000) begin failures++; $display("FAIL bcast_stats got=%06h exp=100000", stats()); end
    endtask

    task automatic test_overflow();
        build_frame(7, STATION, 46, -1);
        // 15 data beats fit, then the reserved entry takes payload byte 45 as the last beat.
        repeat (30) exp_q.delete(15);
        clear_obs();
        m_ready = 1'b0;
        send_frame(-1);
        idle(5);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL ovf_stall_valid got=%0b exp=1", m_valid); end
        checks++; if ({m_data, m_last, m_err} !== 10'h000) begin failures++; $display("FAIL ovf_stall_head got=%03h exp=000", {m_data, m_last, m_err}); end
        checks++; if (stats() !== 24'h001000) begin failures++; $display("FAIL ovf_stats got=%06h exp=001000", stats()); end
        m_ready = 1'b1;
        idle(30);
        checks++; if (got_data.size() !== 16) begin failures++; $display("FAIL ovf_beats got=%0d exp=16", got_data.size()); end
        checks++; if (data_errs() !== 0) begin failures++; $display("FAIL ovf_data got=%0d exp=0 errors", data_errs()); end
        checks++; if (last_errs() !== 0) begin failures++; $display("FAIL ovf_last got=%0d exp=0 errors", last_errs()); end
        checks++; if (final_err() !== 1'b1) begin failures++; $display("FAIL ovf_err got=%0b exp=1", final_err()); end
    endtask

    task automatic test_runt();
        build_frame(3, STATION, 46, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if ({got_data.size() != 0, stats()} !== 25'h0) begin failures++; $display("FAIL short_pre got=%0d beats stats=%06h exp=0 beats stats=000000", got_data.size(), stats()); end
        build_frame(6, STATION, 46, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if ({got_data.size() != 0, stats()} !== 25'h0) begin failures++; $display("FAIL pre6 got=%0d beats stats=%06h exp=0 beats stats=000000", got_data.size(), stats()); end
        build_frame(7, STATION, 46, -1);
        while (tx_q.size() > 8 + 16) void'(tx_q.pop_back());
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 0) begin failures++; $display("FAIL runt16_beats got=%0d exp=0", got_data.size()); end
        checks++; if (stats() !== 24'h000010) begin failures++; $display("FAIL runt16_stats got=%06h exp=000010", stats()); end
        build_frame(7, STATION, 0, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if ({got_data.size() != 0, stats()} !== {1'b0, 24'h000010}) begin failures++; $display("FAIL runt18 got=%0d beats stats=%06h exp=0 beats stats=000010", got_data.size(), stats()); end
        build_frame(7, STATION, 1, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 1) begin failures++; $display("FAIL min19_beats got=%0d exp=1", got_data.size()); end
        checks++; if ({data_errs(), last_errs(), final_err()} !== 65'h0) begin failures++; $display("FAIL min19_beat got=%0d/%0d/%0b exp=0/0/0", data_errs(), last_errs(), final_err()); end
        checks++; if (stats() !== 24'h100000) begin failures++; $display("FAIL min19_stats got=%06h exp=100000", stats()); end
    endtask

    task automatic test_back_to_back();
        build_frame(7, STATION, 46, -1);
        clear_obs();
        send_frame(8 + 14 + 20);
        build_frame(7, STATION, 46, -1);
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 46) begin failures++; $display("FAIL b2b_beats got=%0d exp=46", got_data.size()); end
        checks++; if (data_errs() !== 0) begin failures++; $display("FAIL b2b_data got=%0d exp=0 errors", data_errs()); end
        checks++; if (last_errs() !== 0) begin failures++; $display("FAIL b2b_last got=%0d exp=0 errors", last_errs()); end
        checks++; if (stats() !== 24'h100000) begin failures++; $display("FAIL b2b_stats got=%06h exp=100000", stats()); end
    endtask

    task automatic test_oversize();
        build_frame(7, STATION, 1500, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 1500) begin failures++; $display("FAIL max_beats got=%0d exp=1500", got_data.size()); end
        checks++; if (stats() !== 24'h100000) begin failures++; $display("FAIL max_stats got=%06h exp=100000", stats()); end
        build_frame(7, STATION, 1501, -1);
        clear_obs();
        send_frame(-1);
        idle(20);
        checks++; if (got_data.size() !== 1501) begin failures++; $display("FAIL ovs_beats got=%0d exp=1501", got_data.size()); end
        checks++; if (data_errs() !== 0) begin failures++; $display("FAIL ovs_data got=%0d exp=0 errors", data_errs()); end
        checks++; if (final_err() !== 1'b1) begin failures++; $display("FAIL ovs_err got=%0b exp=1", final_err()); end
        checks++; if (stats() !== 24'h000100) begin failures++; $display("FAIL ovs_stats got=%06h exp=000100", stats()); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_obs();
        test_reset();
        test_accept();
        test_crc_error();
        test_filter();
        test_overflow();
        test_runt();
        test_back_to_back();
        test_oversize();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
